// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin scheduler sharing one uart_tx between NREQ producers.
//            Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*DW-1:0]      i_data,
  output logic [NREQ-1:0]         o_ack,
  output logic [NREQ-1:0]         o_done,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  output logic                    o_busy,
  output logic                    o_tx_start,
  output logic [DW-1:0]           o_tx_data,
  input  logic                    i_tx_ready
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   w_winner;
  logic [DW-1:0]   r_tx_data;
  logic [NREQ-1:0] w_grant_oh;
  logic            w_capture;

  // Descending scan so the candidate closest to the search start is assigned last and wins.
  always_comb begin
    w_winner = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) w_winner = IW'(i);
    end
`else
    for (int i = NREQ; i >= 1; i--) begin
      if (i_req[(int'(r_last) + i) % NREQ]) w_winner = IW'((int'(r_last) + i) % NREQ);
    end
`endif
  end

  assign w_capture  = (r_state == S_IDLE) && (|i_req) && i_tx_ready;
  assign w_grant_oh = NREQ'(1) << r_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_tx_start  = 1'b0;
    o_busy      = 1'b0;
    o_ack       = '0;
    o_done      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_state_nxt = S_START;
      end
      S_START: begin
        o_tx_start  = 1'b1;
        o_busy      = 1'b1;
        o_ack       = w_grant_oh;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        o_busy = 1'b1;
        if (!i_tx_ready) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        o_busy = 1'b1;
        if (i_tx_ready) w_state_nxt = S_DONE;
      end
      // Done pulse gets its own cycle, which also enforces the one-IDLE gap before re-arbitration.
      S_DONE: begin
        o_done      = w_grant_oh;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= IW'(NREQ - 1);
      r_grant   <= '0;
      r_tx_data <= '0;
    end else if (w_capture) begin
      r_last    <= w_winner;
      r_grant   <= w_winner;
      r_tx_data <= i_data[int'(w_winner)*DW +: DW];
    end
  end

  assign o_grant_id = r_grant;
  assign o_tx_data  = r_tx_data;

endmodule
`default_nettype wire
